// File: rtl/branch_ctrl_unit.sv
// branch_ctrl_unit: resolves branches one cycle late, keeps a circular return-address stack and holds flush after a taken branch
module branch_ctrl_unit #(
  parameter int PC_W      = 8,
  parameter int RAS_DEPTH = 4,
  parameter int FLUSH_CYC = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         valid_in,
  input  logic [2:0]                   btype,
  input  logic                         is_call,
  input  logic [3:0]                   flag_mask,
  input  logic [PC_W-1:0]              target,
  input  logic [PC_W-1:0]              pc_next,
  output logic                         b_take,
  output logic [1:0]                   pc_src,
  output logic [PC_W-1:0]              redirect_pc,
  output logic                         flush,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_ovf,
  output logic                         ras_unf
);
  localparam int AW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(FLUSH_CYC + 1);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;
  logic [0:0]      state;
  logic [CW-1:0]   cnt;
  logic [AW-1:0]   sp;
  logic [PC_W-1:0] ras [RAS_DEPTH];
  logic            cond, take, push, pop, full, empty;
  logic [PC_W-1:0] top;
  always_comb begin
    cond = btype == 3'd1 ? flag_mask[0] :
           btype == 3'd2 ? flag_mask[1] :
           btype == 3'd3 ? flag_mask[2] :
           btype == 3'd4 ? flag_mask[3] :
           btype == 3'd5 ? !flag_mask[0] :
           btype[2] & btype[1];
  end
  assign take  = valid_in && state == IDLE && cond;
  assign push  = take && btype == 3'b110 && is_call;
  assign pop   = take && btype == 3'b111;
  assign full  = ras_count == (AW+1)'(RAS_DEPTH);
  assign empty = ras_count == '0;
  assign top   = ras[sp - AW'(1)];
  assign flush = state == FLUSH;
  // sp is the next write slot; when full it points at the oldest entry, so a push overwrites it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      sp          <= '0;
      ras_count   <= '0;
      b_take      <= 1'b0;
      pc_src      <= 2'b00;
      redirect_pc <= '0;
      ras_ovf     <= 1'b0;
      ras_unf     <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) ras[i] <= '0;
    end else begin
      b_take      <= take;
      pc_src      <= !take ? 2'b00 : pop ? 2'b10 : 2'b01;
      redirect_pc <= !take ? '0 : pop ? (empty ? '0 : top) : target;
      if (take) begin
        state <= FLUSH;
        cnt   <= CW'(FLUSH_CYC);
      end else if (state == FLUSH) begin
        state <= cnt == CW'(1) ? IDLE : FLUSH;
        cnt   <= cnt - CW'(1);
      end
      if (push) begin
        ras[sp]   <= pc_next;
        sp        <= sp + AW'(1);
        ras_count <= full ? ras_count : ras_count + (AW+1)'(1);
        ras_ovf   <= ras_ovf | full;
      end
      if (pop) begin
        if (empty) ras_unf <= 1'b1;
        else begin
          sp        <= sp - AW'(1);
          ras_count <= ras_count - (AW+1)'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_branch_ctrl_unit.sv
// tb_branch_ctrl_unit: random and directed branches checked against a queue-based reference via a scoreboard
module tb_branch_ctrl_unit;
  localparam int PC_W = 8, DEPTH = 4, FCYC = 2;
  typedef struct {
    logic       bt;
    logic [1:0] src;
    logic [7:0] rpc;
    logic       fl;
    logic [2:0] cnt;
    logic       ovf;
    logic       unf;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0, valid_in = 1'b0, is_call = 1'b0;
  logic [2:0] btype = '0;
  logic [3:0] flag_mask = '0;
  logic [PC_W-1:0] target = '0, pc_next = '0;
  logic b_take, flush, ras_ovf, ras_unf;
  logic [1:0] pc_src;
  logic [PC_W-1:0] redirect_pc;
  logic [2:0] ras_count;
  int n_chk = 0, n_fail = 0;
  exp_t sb[$];
  int stk[$];
  int fl_rem = 0;
  bit m_ovf = 0, m_unf = 0;

  branch_ctrl_unit #(.PC_W(PC_W), .RAS_DEPTH(DEPTH), .FLUSH_CYC(FCYC)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .btype(btype), .is_call(is_call),
    .flag_mask(flag_mask), .target(target), .pc_next(pc_next), .b_take(b_take),
    .pc_src(pc_src), .redirect_pc(redirect_pc), .flush(flush), .ras_count(ras_count),
    .ras_ovf(ras_ovf), .ras_unf(ras_unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [2:0] bt, input logic c, input logic [3:0] fm,
                      input logic [7:0] tg, input logic [7:0] pn);
    exp_t e;
    bit cond, tk;
    @(negedge clk);
    valid_in = v; btype = bt; is_call = c; flag_mask = fm; target = tg; pc_next = pn;
    case (bt)
      3'd1: cond = fm[0];
      3'd2: cond = fm[1];
      3'd3: cond = fm[2];
      3'd4: cond = fm[3];
      3'd5: cond = !fm[0];
      3'd6, 3'd7: cond = 1;
      default: cond = 0;
    endcase
    tk = v && fl_rem == 0 && cond;
    e = '{default: 0};
    if (tk) begin
      e.bt = 1;
      if (bt == 3'd7) begin
        e.src = 2;
        if (stk.size() == 0) m_unf = 1;
        else e.rpc = 8'(stk.pop_back());
      end else begin
        e.src = 1;
        e.rpc = tg;
        if (bt == 3'd6 && c) begin
          if (stk.size() == DEPTH) begin
            void'(stk.pop_front());
            m_ovf = 1;
          end
          stk.push_back(int'(pn));
        end
      end
    end
    fl_rem = tk ? FCYC : (fl_rem > 0 ? fl_rem - 1 : 0);
    e.fl = fl_rem > 0;
    e.cnt = 3'(stk.size());
    e.ovf = m_ovf;
    e.unf = m_unf;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 3'd0, 0, 4'd0, 8'd0, 8'd0);
  endtask

  task automatic rst_pulse();
    @(negedge clk);
    valid_in = 0;
    rst_n = 0;
    #1;
    chk("async_flush", flush, 0);
    chk("async_b_take", b_take, 0);
    chk("async_ras_count", ras_count, 0);
    stk.delete();
    fl_rem = 0; m_ovf = 0; m_unf = 0;
    sb.push_back('{default: 0});
    @(posedge clk);
    #2 rst_n = 1;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("b_take", b_take, e.bt);
        chk("pc_src", pc_src, e.src);
        chk("redirect_pc", redirect_pc, e.rpc);
        chk("flush", flush, e.fl);
        chk("ras_count", ras_count, e.cnt);
        chk("ras_ovf", ras_ovf, e.ovf);
        chk("ras_unf", ras_unf, e.unf);
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_b_take", b_take, 0);
    chk("rst_pc_src", pc_src, 0);
    chk("rst_redirect", redirect_pc, 0);
    chk("rst_flush", flush, 0);
    chk("rst_ras_count", ras_count, 0);
    chk("rst_ovf", ras_ovf, 0);
    chk("rst_unf", ras_unf, 0);
    #1 rst_n = 1;
    step(1, 3'd1, 0, 4'b0001, 8'h3C, 8'h00); idle(3);
    step(1, 3'd5, 0, 4'b0001, 8'h40, 8'h00);
    step(1, 3'd2, 0, 4'b0010, 8'h50, 8'h00); idle(2);
    step(1, 3'd1, 1, 4'b0001, 8'h60, 8'h77); idle(2);
    step(1, 3'd6, 1, 4'b0000, 8'h80, 8'h11); idle(2);
    step(1, 3'd6, 1, 4'b0000, 8'h90, 8'h22); idle(2);
    step(1, 3'd7, 0, 4'b0000, 8'h00, 8'h00); idle(2);
    step(1, 3'd7, 0, 4'b0000, 8'h00, 8'h00); idle(2);
    for (int i = 1; i <= 5; i++) begin
      step(1, 3'd6, 1, 4'd0, 8'(8'hA0 + i), 8'(8'h10 * i)); idle(2);
    end
    for (int i = 0; i < 5; i++) begin
      step(1, 3'd7, 0, 4'd0, 8'h00, 8'h00); idle(2);
    end
    step(1, 3'd6, 0, 4'd0, 8'hC1, 8'h00);
    step(1, 3'd6, 1, 4'd0, 8'hC2, 8'h33);
    idle(1);
    step(1, 3'd6, 0, 4'd0, 8'hC3, 8'h00); idle(2);
    step(1, 3'd6, 1, 4'd0, 8'hD0, 8'h44);
    rst_pulse();
    step(1, 3'd6, 0, 4'd0, 8'hE5, 8'h00); idle(2);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    repeat (3) @(posedge clk);
    #2;
    chk("sb_drain", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/branch_ctrl_unit.md
BRANCH_CTRL_UNIT -- requirements
Module: branch_ctrl_unit

Interface
- REQ-001 The block SHALL have parameter PC_W, default 8, meaning program-counter width in bits.
- REQ-002 The block SHALL have parameter RAS_DEPTH, default 4, meaning return-address-stack entries (power of two, >=2).
- REQ-003 The block SHALL have parameter FLUSH_CYC, default 2, meaning cycles for which flush is held after a taken branch (>=1).
- REQ-004 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
- REQ-005 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
- REQ-006 The block SHALL have port valid_in, input, 1, branch-type and operands valid this cycle.
- REQ-007 The block SHALL have port btype, input, 3, branch type: 000 NONE, 001 JZ, 010 JN, 011 JC, 100 JV, 101 LOOP, 110 JMP/CALL, 111 RET/RTI.
- REQ-008 The block SHALL have port is_call, input, 1, qualifies btype 110 as CALL (push return address).
- REQ-009 The block SHALL have port flag_mask, input, 4, flags: bit0 Z, bit1 N, bit2 C, bit3 V.
- REQ-010 The block SHALL have port target, input, PC_W, branch/jump destination.
- REQ-011 The block SHALL have port pc_next, input, PC_W, address following the branch (return address for CALL).
- REQ-012 The block SHALL have port b_take, output, 1, registered branch-taken pulse.
- REQ-013 The block SHALL have port pc_src, output, 2, registered PC select: 00 NORM, 01 target, 10 stack.
- REQ-014 The block SHALL have port redirect_pc, output, PC_W, registered redirect address.
- REQ-015 The block SHALL have port flush, output, 1, squash younger pipeline stages.
- REQ-016 The block SHALL have port ras_count, output, clog2(RAS_DEPTH)+1, current stack occupancy.
- REQ-017 The block SHALL have ports ras_ovf and ras_unf, outputs, 1 each, sticky overflow/underflow flags.

Function
- REQ-018 Condition SHALL be: JZ Z=1; JN N=1; JC C=1; JV V=1; LOOP Z=0; JMP and RET always; NONE never.
- REQ-019 A branch SHALL be accepted only when valid_in=1 and the FSM is in IDLE; inputs during FLUSH SHALL be ignored, with no stack change and no outputs.
- REQ-020 Latency SHALL be one cycle: an accepted taken branch in cycle N gives b_take=1 for exactly cycle N+1.
- REQ-021 On a taken conditional branch, LOOP or JMP, the block SHALL drive pc_src=01 and redirect_pc=target.
- REQ-022 On a taken RET, the block SHALL drive pc_src=10 and redirect_pc=top-of-stack, then pop one entry.
- REQ-023 Not-taken or NONE SHALL give b_take=0, pc_src=00 and redirect_pc=0 the next cycle; the FSM stays IDLE.
- REQ-024 CALL (btype 110, is_call=1) SHALL push pc_next and jump per REQ-021 in the same accepted cycle.
- REQ-025 is_call SHALL be ignored for every btype other than 110.
- REQ-026 The stack SHALL be circular; a push when full SHALL overwrite the oldest entry, keep ras_count=RAS_DEPTH, and set ras_ovf.
- REQ-027 A RET when empty SHALL still be taken with redirect_pc=0, leave ras_count=0, and set ras_unf.
- REQ-028 ras_ovf and ras_unf SHALL clear only on reset.
- REQ-029 The FSM SHALL have two states, IDLE and FLUSH; a taken branch moves IDLE->FLUSH.
- REQ-030 flush SHALL be 1 for exactly FLUSH_CYC cycles, starting in the b_take cycle.
- REQ-031 The FSM SHALL move FLUSH->IDLE when the down-counter reaches 1; acceptance resumes the following cycle.
- REQ-032 Outside the b_take cycle, b_take, pc_src and redirect_pc SHALL be 0.

Reset
- REQ-033 When rst_n=0, the block SHALL asynchronously set: FSM IDLE, flush counter 0, stack pointer 0, ras_count 0, all entries 0, b_take 0, pc_src 00, redirect_pc 0, flush 0, ras_ovf 0, ras_unf 0.
- REQ-034 Reset asserted mid-FLUSH SHALL end the flush immediately and discard the in-flight branch.
- REQ-035 After rst_n deassertion, the first rising edge SHALL be able to accept a branch.

Verification
- REQ-036 JZ, flag_mask=0001, target=0x3C -> next cycle b_take=1, pc_src=01, redirect_pc=0x3C; flush high 2 cycles.
- REQ-037 LOOP, flag_mask=0001 -> b_take=0, pc_src=00, no flush; then JN, flag_mask=0010 -> taken.
- REQ-038 CALL pc_next=0x11, CALL pc_next=0x22, RET, RET -> redirect_pc 0x22 then 0x11, pc_src=10; ras_count 2->0.
- REQ-039 5 CALLs (depth 4) -> ras_ovf=1, ras_count=4; then 5 RETs -> 4 newest addresses in LIFO order, 5th gives redirect_pc=0 and ras_unf=1.
- REQ-040 JMP, then JMP with valid_in=1 in the next cycle (during FLUSH) -> second JMP ignored; a JMP 2 cycles after the first flush cycle is accepted.
- REQ-041 rst_n pulsed low in the first flush cycle -> flush, b_take and ras_count are 0 immediately, asynchronously.
